// File: rtl/acc_cpu_pkg.sv
// Shared opcodes, FSM states, control bundle and default sizing
// for the multi-port accumulator CPU.
package acc_cpu_pkg;

    localparam int DEF_DATA_WIDTH   = 11;
    localparam int DEF_ADDR_WIDTH   = 6;
    localparam int DEF_OPCODE_WIDTH = 5;
    localparam int DEF_NUM_PORTS    = 4;
    localparam int DEF_STACK_DEPTH  = 8;
    localparam int OPCODE_BITS      = 5;

    typedef enum logic [4:0] {
        OP_NOP   = 5'd0,
        OP_LOAD  = 5'd1,
        OP_STORE = 5'd2,
        OP_ADD   = 5'd3,
        OP_SUB   = 5'd4,
        OP_AND   = 5'd5,
        OP_OR    = 5'd6,
        OP_XOR   = 5'd7,
        OP_NOT   = 5'd8,
        OP_SHR   = 5'd9,
        OP_SHL   = 5'd10,
        OP_INC   = 5'd11,
        OP_DEC   = 5'd12,
        OP_JMP   = 5'd13,
        OP_JZ    = 5'd14,
        OP_JC    = 5'd15,
        OP_PUSH  = 5'd16,
        OP_POP   = 5'd17,
        OP_CALL  = 5'd18,
        OP_RET   = 5'd19,
        OP_IN    = 5'd20,
        OP_OUT   = 5'd21,
        OP_LDI   = 5'd22,
        OP_HALT  = 5'd23
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_e;

    typedef struct packed {
        logic acc_wr;
        logic store;
        logic push;
        logic pop;
        logic out;
        logic halt;
        logic bad;
    } exec_ctl_t;

endpackage

// File: rtl/acc_cpu_stack.sv
// LIFO used for PUSH/POP data and CALL/RET return addresses.
module acc_cpu_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             full,
    output logic             empty
);

    localparam int IW  = $clog2(DEPTH);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam logic [SPW-1:0] FULL_CNT = SPW'(DEPTH);
    localparam logic [SPW-1:0] SP_ONE   = SPW'(1);

    generate
        if (DEPTH < 2) begin : g_bad_depth
            $error("acc_cpu_stack: DEPTH must be at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] entries [DEPTH];
    logic [SPW-1:0]   sp;

    assign full     = (sp == FULL_CNT);
    assign empty    = (sp == '0);
    assign top_data = entries[IW'(sp - SP_ONE)];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_ONE;
        end else if (pop && !empty) begin
            sp <= sp - SP_ONE;
        end
    end

    // Contents are left alone on reset; only the pointer matters.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            entries[sp[IW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/multiport_acc_cpu.sv
// Two-cycle accumulator CPU with unified program/data memory,
// hardware stack and a bank of registered I/O channels.
module multiport_acc_cpu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
    parameter int NUM_PORTS    = DEF_NUM_PORTS,
    parameter int STACK_DEPTH  = DEF_STACK_DEPTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            load_en,
    input  logic [ADDR_WIDTH-1:0]           load_addr,
    input  logic [DATA_WIDTH-1:0]           load_data,
    input  logic                            start,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_in,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] port_out,
    output logic [NUM_PORTS-1:0]            port_oe,
    output logic [DATA_WIDTH-1:0]           acc_out,
    output logic [ADDR_WIDTH-1:0]           pc_out,
    output logic                            zero_flag,
    output logic                            carry_flag,
    output logic                            busy,
    output logic                            halted,
    output logic                            fault
);

    localparam int OPW       = DATA_WIDTH - OPCODE_WIDTH;
    localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

    generate
        if (OPW < ADDR_WIDTH || NUM_PORTS < 1 ||
            NUM_PORTS > (1 << OPW) || OPCODE_WIDTH < OPCODE_BITS) begin : g_bad_params
            $error("multiport_acc_cpu: inconsistent parameters");
        end
    endgenerate

    localparam logic [ADDR_WIDTH-1:0] PC_ONE  = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH:0]   ACC_ONE = (DATA_WIDTH + 1)'(1);
    localparam logic [OPW:0]          NP_LIM  = (OPW + 1)'(NUM_PORTS);

    state_e                  state;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]   ir;
    logic [DATA_WIDTH-1:0]   acc;
    logic [ADDR_WIDTH-1:0]   pc;
    logic                    z;
    logic                    c;

    logic [OPCODE_WIDTH-1:0] op_field;
    logic [OPW-1:0]          opnd;
    logic [ADDR_WIDTH-1:0]   a;
    logic [DATA_WIDTH-1:0]   m;
    logic                    op_hi_bad;
    logic                    port_bad;
    logic [DATA_WIDTH-1:0]   in_word;

    exec_ctl_t               ctl;
    logic [DATA_WIDTH:0]     sum;
    logic [DATA_WIDTH-1:0]   acc_n;
    logic                    z_n;
    logic                    c_n;
    logic [ADDR_WIDTH-1:0]   pc_inc;
    logic [ADDR_WIDTH-1:0]   pc_n;
    logic [DATA_WIDTH-1:0]   push_val;

    logic                    in_exec;
    logic                    can_load;
    logic                    do_start;
    logic                    stk_full;
    logic                    stk_empty;
    logic [DATA_WIDTH-1:0]   stk_top;

    assign op_field  = ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign opnd      = ir[OPW-1:0];
    assign a         = opnd[ADDR_WIDTH-1:0];
    assign m         = mem[a];
    assign op_hi_bad = ((op_field >> OPCODE_BITS) != '0);
    assign port_bad  = ({1'b0, opnd} >= NP_LIM);
    assign pc_inc    = pc + PC_ONE;

    assign in_exec  = (state == S_EXEC);
    assign can_load = (state == S_IDLE) || (state == S_HALT);
    assign do_start = can_load && start && !load_en;

    always_comb begin
        in_word = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (opnd == OPW'(p)) begin
                in_word = port_in[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        ctl      = '0;
        ctl.bad  = op_hi_bad;
        sum      = '0;
        acc_n    = acc;
        c_n      = c;
        pc_n     = pc_inc;
        push_val = acc;
        unique case (op_field[OPCODE_BITS-1:0])
            OP_NOP:   ;
            OP_LOAD:  begin acc_n = m; ctl.acc_wr = 1'b1; end
            OP_STORE: ctl.store = 1'b1;
            OP_ADD: begin
                sum = {1'b0, acc} + {1'b0, m};
                acc_n = sum[DATA_WIDTH-1:0];
                c_n = sum[DATA_WIDTH];
                ctl.acc_wr = 1'b1;
            end
            OP_SUB: begin
                sum = {1'b0, acc} - {1'b0, m};
                acc_n = sum[DATA_WIDTH-1:0];
                c_n = sum[DATA_WIDTH];
                ctl.acc_wr = 1'b1;
            end
            OP_AND:   begin acc_n = acc & m; ctl.acc_wr = 1'b1; end
            OP_OR:    begin acc_n = acc | m; ctl.acc_wr = 1'b1; end
            OP_XOR:   begin acc_n = acc ^ m; ctl.acc_wr = 1'b1; end
            OP_NOT:   begin acc_n = ~acc; ctl.acc_wr = 1'b1; end
            OP_SHR: begin
                acc_n = {1'b0, acc[DATA_WIDTH-1:1]};
                c_n = acc[0];
                ctl.acc_wr = 1'b1;
            end
            OP_SHL: begin
                acc_n = {acc[DATA_WIDTH-2:0], 1'b0};
                c_n = acc[DATA_WIDTH-1];
                ctl.acc_wr = 1'b1;
            end
            OP_INC: begin
                sum = {1'b0, acc} + ACC_ONE;
                acc_n = sum[DATA_WIDTH-1:0];
                c_n = sum[DATA_WIDTH];
                ctl.acc_wr = 1'b1;
            end
            OP_DEC: begin
                sum = {1'b0, acc} - ACC_ONE;
                acc_n = sum[DATA_WIDTH-1:0];
                c_n = sum[DATA_WIDTH];
                ctl.acc_wr = 1'b1;
            end
            OP_JMP:   pc_n = a;
            OP_JZ:    if (z) pc_n = a;
            OP_JC:    if (c) pc_n = a;
            OP_PUSH:  begin ctl.push = 1'b1; ctl.bad = stk_full; end
            OP_POP: begin
                acc_n = stk_top;
                ctl.acc_wr = 1'b1;
                ctl.pop = 1'b1;
                ctl.bad = stk_empty;
            end
            OP_CALL: begin
                push_val = DATA_WIDTH'(pc_inc);
                pc_n = a;
                ctl.push = 1'b1;
                ctl.bad = stk_full;
            end
            OP_RET: begin
                pc_n = stk_top[ADDR_WIDTH-1:0];
                ctl.pop = 1'b1;
                ctl.bad = stk_empty;
            end
            OP_IN: begin
                acc_n = in_word;
                ctl.acc_wr = 1'b1;
                ctl.bad = port_bad;
            end
            OP_OUT:   begin ctl.out = 1'b1; ctl.bad = port_bad; end
            OP_LDI:   begin acc_n = DATA_WIDTH'(opnd); ctl.acc_wr = 1'b1; end
            OP_HALT:  ctl.halt = 1'b1;
            default:  ctl.bad = 1'b1;
        endcase
        if (op_hi_bad) ctl.bad = 1'b1;
        z_n = ctl.acc_wr ? (acc_n == '0) : z;
    end

    acc_cpu_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .clear     (do_start),
        .push      (in_exec && ctl.push && !ctl.bad),
        .pop       (in_exec && ctl.pop && !ctl.bad),
        .push_data (push_val),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Reset blocks any write, including a STORE caught mid-EXEC.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (load_en && can_load) begin
                mem[load_addr] <= load_data;
            end else if (in_exec && ctl.store && !ctl.bad) begin
                mem[a] <= acc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ir       <= '0;
            acc      <= '0;
            pc       <= '0;
            z        <= 1'b0;
            c        <= 1'b0;
            port_out <= '0;
            port_oe  <= '0;
            busy     <= 1'b0;
            halted   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_HALT: begin
                    if (do_start) begin
                        state  <= S_FETCH;
                        pc     <= '0;
                        acc    <= '0;
                        z      <= 1'b0;
                        c      <= 1'b0;
                        busy   <= 1'b1;
                        halted <= 1'b0;
                    end
                end
                S_FETCH: begin
                    ir    <= mem[pc];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (ctl.bad) begin
                        state <= S_FAULT;
                        busy  <= 1'b0;
                        fault <= 1'b1;
                    end else begin
                        acc <= acc_n;
                        z   <= z_n;
                        c   <= c_n;
                        pc  <= pc_n;
                        if (ctl.out) begin
                            for (int p = 0; p < NUM_PORTS; p++) begin
                                if (opnd == OPW'(p)) begin
                                    port_out[p*DATA_WIDTH +: DATA_WIDTH] <= acc;
                                    port_oe[p] <= 1'b1;
                                end
                            end
                        end
                        if (ctl.halt) begin
                            state  <= S_HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_FAULT: ;
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign acc_out    = acc;
    assign pc_out     = pc;
    assign zero_flag  = z;
    assign carry_flag = c;

endmodule

// File: tb/tb_multiport_acc_cpu.sv
// Directed bench for multiport_acc_cpu: ALU vector table plus
// hand-written control-flow, stack, I/O and reset sequences.
module tb_multiport_acc_cpu;

    localparam int DW = 11;
    localparam int AW = 6;
    localparam int NP = 4;

    localparam logic [4:0] NOP = 5'd0, LOAD = 5'd1, STORE = 5'd2;
    localparam logic [4:0] ADD = 5'd3, SUB = 5'd4, AND_ = 5'd5;
    localparam logic [4:0] OR_ = 5'd6, XOR_ = 5'd7, NOT_ = 5'd8;
    localparam logic [4:0] SHR = 5'd9, SHL = 5'd10, INC = 5'd11;
    localparam logic [4:0] DEC = 5'd12, JC = 5'd15;
    localparam logic [4:0] PUSH = 5'd16, POP = 5'd17, CALL = 5'd18;
    localparam logic [4:0] RET = 5'd19, IN_ = 5'd20, OUT_ = 5'd21;
    localparam logic [4:0] LDI = 5'd22, HALT = 5'd23;

    logic             clk = 1'b0;
    logic             reset;
    logic             load_en;
    logic [AW-1:0]    load_addr;
    logic [DW-1:0]    load_data;
    logic             start;
    logic [NP*DW-1:0] port_in;
    logic [NP*DW-1:0] port_out;
    logic [NP-1:0]    port_oe;
    logic [DW-1:0]    acc_out;
    logic [AW-1:0]    pc_out;
    logic             zero_flag;
    logic             carry_flag;
    logic             busy;
    logic             halted;
    logic             fault;

    int checks = 0;
    int errors = 0;

    multiport_acc_cpu dut (
        .clk        (clk),
        .reset      (reset),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .port_in    (port_in),
        .port_out   (port_out),
        .port_oe    (port_oe),
        .acc_out    (acc_out),
        .pc_out     (pc_out),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .busy       (busy),
        .halted     (halted),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]    op;
        logic [DW-1:0] init;
        logic [DW-1:0] mval;
        logic [DW-1:0] eacc;
        logic          ez;
        logic          ec;
    } vec_t;

    function automatic logic [DW-1:0] enc(input logic [4:0] op,
                                          input logic [5:0] o);
        return {op, o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic put(input logic [AW-1:0] addr, input logic [DW-1:0] d);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!(halted || fault) && n < 200) begin
            tick();
            n++;
        end
        if (!(halted || fault)) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=busy required=done", name);
        end
    endtask

    vec_t vt[16];

    initial begin
        reset     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        start     = 1'b0;
        port_in   = '0;
        #2;
        do_reset();

        chk("rst_acc", acc_out, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_flags", {zero_flag, carry_flag}, 0);
        chk("rst_status", {busy, halted, fault}, 0);
        chk("rst_port_out", port_out, 0);
        chk("rst_port_oe", port_oe, 0);

        // load_en with start: write only, no run
        load_en = 1'b1; start = 1'b1;
        load_addr = 6'd60; load_data = 11'h2AB;
        tick();
        load_en = 1'b0; start = 1'b0;
        chk("load_start_busy", busy, 0);

        // ALU vectors: 0 LOAD 50; 1 op 51; 2 HALT
        vt[0]  = '{ADD,  11'h003, 11'h004, 11'h007, 1'b0, 1'b0};
        vt[1]  = '{ADD,  11'h7FF, 11'h001, 11'h000, 1'b1, 1'b1};
        vt[2]  = '{SUB,  11'h005, 11'h003, 11'h002, 1'b0, 1'b0};
        vt[3]  = '{SUB,  11'h003, 11'h005, 11'h7FE, 1'b0, 1'b1};
        vt[4]  = '{AND_, 11'h5AA, 11'h0F0, 11'h0A0, 1'b0, 1'b0};
        vt[5]  = '{OR_,  11'h400, 11'h001, 11'h401, 1'b0, 1'b0};
        vt[6]  = '{XOR_, 11'h155, 11'h155, 11'h000, 1'b1, 1'b0};
        vt[7]  = '{NOT_, 11'h000, 11'h000, 11'h7FF, 1'b0, 1'b0};
        vt[8]  = '{SHR,  11'h003, 11'h000, 11'h001, 1'b0, 1'b1};
        vt[9]  = '{SHL,  11'h401, 11'h000, 11'h002, 1'b0, 1'b1};
        vt[10] = '{INC,  11'h7FF, 11'h000, 11'h000, 1'b1, 1'b1};
        vt[11] = '{DEC,  11'h000, 11'h000, 11'h7FF, 1'b0, 1'b1};
        vt[12] = '{DEC,  11'h001, 11'h000, 11'h000, 1'b1, 1'b0};
        vt[13] = '{LDI,  11'h123, 11'h000, 11'h033, 1'b0, 1'b0};
        vt[14] = '{NOP,  11'h000, 11'h000, 11'h000, 1'b1, 1'b0};
        vt[15] = '{LOAD, 11'h000, 11'h6D5, 11'h6D5, 1'b0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            put(6'd50, vt[i].init);
            put(6'd51, vt[i].mval);
            put(6'd0, enc(LOAD, 6'd50));
            put(6'd1, enc(vt[i].op, 6'd51));
            put(6'd2, enc(HALT, 6'd0));
            go();
            wait_done($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_acc", i), acc_out, vt[i].eacc);
            chk($sformatf("vec%0d_z", i), zero_flag, vt[i].ez);
            chk($sformatf("vec%0d_c", i), carry_flag, vt[i].ec);
            chk($sformatf("vec%0d_halt", i), {halted, fault}, 2'b10);
        end

        // Earlier simultaneous load+start wrote mem[60]
        put(6'd0, enc(LOAD, 6'd60));
        put(6'd1, enc(HALT, 6'd0));
        go();
        wait_done("loadstart_rd");
        chk("load_start_mem", acc_out, 11'h2AB);

        // LDI 5; ADD 34; STORE 36; HALT
        do_reset();
        put(6'd34, 11'd7);
        put(6'd0, enc(LDI, 6'd5));
        put(6'd1, enc(ADD, 6'd34));
        put(6'd2, enc(STORE, 6'd36));
        put(6'd3, enc(HALT, 6'd0));
        go();
        ticks(7);
        chk("s1_halt_at7", halted, 0);
        tick();
        chk("s1_halt_at8", halted, 1);
        chk("s1_acc", acc_out, 12);
        put(6'd0, enc(LOAD, 6'd36));
        put(6'd1, enc(HALT, 6'd0));
        go();
        wait_done("s1_rd");
        chk("s1_mem36", acc_out, 12);

        // STORE then LOAD of the same address
        put(6'd0, enc(LDI, 6'd9));
        put(6'd1, enc(STORE, 6'd37));
        put(6'd2, enc(LOAD, 6'd37));
        put(6'd3, enc(HALT, 6'd0));
        put(6'd37, 11'h000);
        go();
        wait_done("st_ld");
        chk("st_ld_acc", acc_out, 9);

        // LOAD 10; INC; JC 40
        do_reset();
        put(6'd10, 11'd2047);
        put(6'd0, enc(LOAD, 6'd10));
        put(6'd1, enc(INC, 6'd0));
        put(6'd2, enc(JC, 6'd40));
        put(6'd40, enc(HALT, 6'd0));
        go();
        ticks(6);
        chk("s2_pc", pc_out, 40);
        chk("s2_acc", acc_out, 0);
        chk("s2_zc", {zero_flag, carry_flag}, 2'b11);

        // IN 2; OUT 0; OUT 5
        do_reset();
        port_in[2*DW +: DW] = 11'h155;
        put(6'd0, enc(IN_, 6'd2));
        put(6'd1, enc(OUT_, 6'd0));
        put(6'd2, enc(OUT_, 6'd5));
        go();
        wait_done("s3");
        chk("s3_port0", port_out[0 +: DW], 11'h155);
        chk("s3_port_hi", port_out[DW +: 3*DW], 0);
        chk("s3_oe", port_oe, 4'b0001);
        chk("s3_fault", {busy, halted, fault}, 3'b001);
        chk("s3_pc", pc_out, 2);
        go();
        chk("s3_fault_sticky", {busy, fault}, 2'b01);

        // 9 PUSH
        do_reset();
        for (int i = 0; i < 9; i++) put(AW'(i), enc(PUSH, 6'd0));
        put(6'd9, enc(HALT, 6'd0));
        go();
        wait_done("push9");
        chk("push9_fault", fault, 1);
        chk("push9_pc", pc_out, 8);

        // LDI 3; CALL 20; HALT / 20: INC; RET
        do_reset();
        put(6'd0, enc(LDI, 6'd3));
        put(6'd1, enc(CALL, 6'd20));
        put(6'd2, enc(HALT, 6'd0));
        put(6'd20, enc(INC, 6'd0));
        put(6'd21, enc(RET, 6'd0));
        go();
        ticks(4);
        chk("call_pc", pc_out, 20);
        ticks(4);
        chk("ret_pc", pc_out, 2);
        wait_done("callret");
        chk("callret_acc", acc_out, 4);
        chk("callret_status", {halted, fault}, 2'b10);

        // LDI 7; PUSH; LDI 0; POP; HALT
        put(6'd0, enc(LDI, 6'd7));
        put(6'd1, enc(PUSH, 6'd0));
        put(6'd2, enc(LDI, 6'd0));
        put(6'd3, enc(POP, 6'd0));
        put(6'd4, enc(HALT, 6'd0));
        go();
        wait_done("pushpop");
        chk("pushpop_acc", acc_out, 7);
        chk("pushpop_z", zero_flag, 0);

        // POP on empty
        put(6'd0, enc(POP, 6'd0));
        go();
        wait_done("pop_empty");
        chk("pop_empty_fault", fault, 1);
        chk("pop_empty_pc", pc_out, 0);

        // Reset during STORE EXEC
        do_reset();
        put(6'd45, 11'h123);
        put(6'd0, enc(LDI, 6'd9));
        put(6'd1, enc(OUT_, 6'd1));
        put(6'd2, enc(STORE, 6'd45));
        put(6'd3, enc(HALT, 6'd0));
        go();
        ticks(5);
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_acc", acc_out, 0);
        chk("mid_pc", pc_out, 0);
        chk("mid_status", {busy, halted, fault, zero_flag, carry_flag}, 0);
        chk("mid_ports", {port_out, port_oe}, 0);
        put(6'd0, enc(LOAD, 6'd45));
        put(6'd1, enc(HALT, 6'd0));
        go();
        wait_done("mid_rerun");
        chk("mid_mem45", acc_out, 11'h123);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multiport_acc_cpu.md
MULTIPORT_ACC_CPU -- requirements
Module: multiport_acc_cpu

Interface
REQ-001 Parameters (name, default, meaning), SHALL be:
- DATA_WIDTH, 11: instruction/data word width.
- ADDR_WIDTH, 6: program/data memory address width.
- OPCODE_WIDTH, 5: opcode field width, taken from the word MSBs.
- NUM_PORTS, 4: I/O channel count.
- STACK_DEPTH, 8: hardware stack entries.
REQ-002 Ports (name, direction, width, meaning), SHALL be:
- clk, in, 1: the single clock.
- reset, in, 1: synchronous, active-high reset.
- load_en, in, 1: program-load write strobe.
- load_addr, in, ADDR_WIDTH: load write address.
- load_data, in, DATA_WIDTH: load write word.
- start, in, 1: begin execution.
- port_in, in, NUM_PORTS*DATA_WIDTH: channel inputs; channel p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
- port_out, out, NUM_PORTS*DATA_WIDTH: registered channel outputs.
- port_oe, out, NUM_PORTS: per-channel output enable.
- acc_out, out, DATA_WIDTH: accumulator.
- pc_out, out, ADDR_WIDTH: program counter.
- zero_flag, out, 1: Z flag.
- carry_flag, out, 1: C flag.
- busy, out, 1: executing.
- halted, out, 1: in HALT.
- fault, out, 1: in FAULT.
REQ-003 Elaboration SHALL fail if DATA_WIDTH-OPCODE_WIDTH < ADDR_WIDTH or NUM_PORTS > 2^(DATA_WIDTH-OPCODE_WIDTH).

Function
REQ-004 FSM states SHALL be IDLE, FETCH, EXEC, HALT, FAULT; busy=1 exactly in FETCH/EXEC.
REQ-005 Transitions SHALL be:
- IDLE/HALT + start=1 and load_en=0 -> FETCH, with pc, sp, acc, Z, C cleared.
- FETCH -> EXEC.
- EXEC -> FETCH, HALT (HALT opcode) or FAULT.
- FAULT exits only via reset.
REQ-006 load_en SHALL write load_data to mem[load_addr] only in IDLE or HALT; it is ignored in other states; load_en=1 with start=1 performs the write and does not start.
REQ-007 FETCH SHALL register mem[pc] into the instruction register; EXEC SHALL execute it; every instruction takes exactly 2 cycles.
REQ-008 Operand field SHALL be word[DATA_WIDTH-OPCODE_WIDTH-1:0]; its low ADDR_WIDTH bits form address a.
REQ-009 Opcodes SHALL be:
- 0 NOP; 1 LOAD acc=mem[a]; 2 STORE mem[a]=acc; 3 ADD; 4 SUB; 5 AND; 6 OR; 7 XOR (each with mem[a]).
- 8 NOT; 9 SHR (logical); 10 SHL; 11 INC; 12 DEC.
- 13 JMP; 14 JZ; 15 JC; 16 PUSH; 17 POP; 18 CALL; 19 RET.
- 20 IN acc=port_in[operand]; 21 OUT port_out[operand]=acc and port_oe[operand]=1.
- 22 LDI acc=zero-extended operand; 23 HALT; 24-31 illegal.
REQ-010 ADD/INC SHALL set C=carry-out; SUB/DEC SHALL set C=borrow; SHL/SHR SHALL set C=shifted-out bit; all other ops leave C unchanged.
REQ-011 Every acc-writing op SHALL set Z=(new acc==0); other ops leave Z unchanged.
REQ-012 pc SHALL increment modulo 2^ADDR_WIDTH (63 wraps to 0) unless a jump is taken; JMP/JZ/JC/CALL/RET load the target instead; CALL pushes pc+1.
REQ-013 PUSH/CALL on a full stack, POP/RET on an empty stack, IN/OUT with operand >= NUM_PORTS, and opcodes 24-31 SHALL enter FAULT with no architectural update and pc_out holding the faulting address.
REQ-014 Arithmetic SHALL be modulo 2^DATA_WIDTH; a STORE followed immediately by a LOAD of the same address SHALL return the stored value.
REQ-015 port_out/port_oe SHALL hold their values until the next OUT to the same channel or reset.

Reset
REQ-016 On reset=1 at a clk edge the block SHALL enter IDLE and clear acc, pc, sp, Z, C, port_out, port_oe, busy, halted and fault to 0; reset overrides start and load_en.
REQ-017 Memory contents SHALL NOT be cleared by reset; reset mid-execution aborts the instruction in flight with no memory write.

Structure
REQ-018 Package acc_cpu_pkg SHALL hold the opcode enum, the state enum and the default parameter constants.
REQ-019 The stack SHALL be sub-module acc_cpu_stack (LIFO, STACK_DEPTH x ADDR_WIDTH-or-DATA_WIDTH entries, full/empty outputs, synchronous reset).

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Load mem[34]=7, program LDI 5; ADD 34; STORE 36; HALT -> acc=12, mem[36]=12, halted=1 exactly 8 cycles after start.
- mem[10]=2047; LOAD 10; INC -> acc=0, Z=1, C=1; a following JC 40 sets pc_out=40.
- port_in[2]=0x155; IN 2; OUT 0 -> port_out[0]=0x155, port_oe=4'b0001; OUT 5 -> fault=1, pc_out=faulting address.
- 9 consecutive PUSH -> fault on the 9th; CALL/RET round trip returns to call address+1; POP on empty -> fault.
- Reset asserted during EXEC of STORE -> memory unchanged, all outputs 0, IDLE; a subsequent start reruns from pc 0.
